// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode/execute control inputs, instruction-memory port and IF/ID outputs.
// The fetch stage drives through 'master'; the CPU side connects through 'slave'.
interface fetch_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_pred_taken;
    logic        fetch_fault;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, if_pc, if_inst, if_valid, if_pred_taken, fetch_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, if_pc, if_inst, if_valid, if_pred_taken, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, IF/ID register, redirect/stall handling, sticky fault.
// Optional static branch prediction is enabled by defining FETCH_STATIC_PREDICT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      bus
);
    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        if_pred_q, if_pred_d;
    logic        fault_q, fault_d;

    logic [31:0] next_pc;
    logic        pred_taken;
    logic        misaligned;

    assign misaligned = (pc_q[1:0] != 2'b00);

`ifdef FETCH_STATIC_PREDICT_EN
    logic [6:0]  opcode;
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    assign opcode = bus.imem_data[6:0];
    assign j_imm  = {{12{bus.imem_data[31]}}, bus.imem_data[19:12], bus.imem_data[20],
                     bus.imem_data[30:21], 1'b0};
    assign b_imm  = {{20{bus.imem_data[31]}}, bus.imem_data[7], bus.imem_data[30:25],
                     bus.imem_data[11:8], 1'b0};

    // Backward conditional branches are predicted taken (loop heuristic); JAL always is.
    always_comb begin
        next_pc    = pc_q + 32'd4;
        pred_taken = 1'b0;
        if (opcode == 7'b1101111) begin
            next_pc    = pc_q + j_imm;
            pred_taken = 1'b1;
        end else if (opcode == 7'b1100011 && bus.imem_data[31]) begin
            next_pc    = pc_q + b_imm;
            pred_taken = 1'b1;
        end
    end
`else
    assign next_pc    = pc_q + 32'd4;
    assign pred_taken = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'h0;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
            if_pred_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            if_pred_q  <= if_pred_d;
            fault_q    <= fault_d;
        end
    end

    // A redirect outranks the misalignment check, so a bad target is only caught on its own fetch.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && !bus.redirect_valid && misaligned) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if_pred_d  = if_pred_q;
        fault_d    = fault_q;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d       = bus.redirect_pc;
                    if_pc_d    = bus.redirect_pc;
                    if_inst_d  = NOP_INST;
                    if_valid_d = 1'b0;
                    if_pred_d  = 1'b0;
                end else if (misaligned) begin
                    fault_d    = 1'b1;
                    if_inst_d  = NOP_INST;
                    if_valid_d = 1'b0;
                    if_pred_d  = 1'b0;
                end else if (!bus.stall) begin
                    pc_d       = next_pc;
                    if_pc_d    = pc_q;
                    if_inst_d  = bus.imem_data;
                    if_valid_d = 1'b1;
                    if_pred_d  = pred_taken;
                end
            end
            default: begin
                fault_d = 1'b1;
            end
        endcase
    end

    assign bus.imem_addr     = pc_q;
    assign bus.if_pc         = if_pc_q;
    assign bus.if_inst       = if_inst_q;
    assign bus.if_valid      = if_valid_q;
    assign bus.if_pred_taken = if_pred_q;
    assign bus.fetch_fault   = fault_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an abstract fetch model checked every cycle plus literal
// expectations taken from hand-worked scenarios.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    fetch_stage_if bus();

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_read(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            32'h0000_0020: return 32'hFE00_0EE3;
            default:       return {a[19:0], 12'h013};
        endcase
    endfunction

    assign bus.imem_data = imem_read(bus.imem_addr);

    // Model: where the fetch goes after fetching word 'inst' at 'pc'.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                               output logic taken);
        logic signed [20:0] joff;
        logic signed [12:0] boff;
        taken = 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
        joff = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        boff = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (inst[6:0] == 7'b1101111) begin
            taken = 1'b1;
            return pc + 32'(joff);
        end
        if (inst[6:0] == 7'b1100011 && boff < 0) begin
            taken = 1'b1;
            return pc + 32'(boff);
        end
`else
        joff = '0;
        boff = '0;
        if (joff != 0 || boff != 0) taken = 1'b1;
`endif
        return pc + 32'd4;
    endfunction

    logic [31:0] m_pc, m_if_pc, m_inst;
    logic        m_valid, m_pred, m_fault;

    // Halted is simply "fault has been raised": nothing but reset moves the model then.
    always @(posedge clk) begin
        logic [31:0] inst, nxt;
        logic        tk;
        if (rst) begin
            m_pc <= 32'h0; m_if_pc <= 32'h0; m_inst <= NOP;
            m_valid <= 1'b0; m_pred <= 1'b0; m_fault <= 1'b0;
        end else if (!m_fault) begin
            if (bus.redirect_valid) begin
                m_pc <= bus.redirect_pc; m_if_pc <= bus.redirect_pc;
                m_inst <= NOP; m_valid <= 1'b0; m_pred <= 1'b0;
            end else if (m_pc % 4 != 0) begin
                m_fault <= 1'b1; m_inst <= NOP; m_valid <= 1'b0; m_pred <= 1'b0;
            end else if (!bus.stall) begin
                inst = imem_read(m_pc);
                nxt  = model_next(m_pc, inst, tk);
                m_if_pc <= m_pc; m_inst <= inst; m_valid <= 1'b1;
                m_pred <= tk; m_pc <= nxt;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model imem_addr", bus.imem_addr, m_pc);
            check("model if_pc", bus.if_pc, m_if_pc);
            check("model if_inst", bus.if_inst, m_inst);
            check("model if_valid", 32'(bus.if_valid), 32'(m_valid));
            check("model if_pred_taken", 32'(bus.if_pred_taken), 32'(m_pred));
            check("model fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
        end
    end

    task automatic tick(input logic s, input logic rv, input logic [31:0] rpc);
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #2;
        $display("txn t=%0t stall=%0b rv=%0b rpc=%h -> addr=%h if_pc=%h inst=%h v=%0b p=%0b flt=%0b",
                 $time, s, rv, rpc, bus.imem_addr, bus.if_pc, bus.if_inst, bus.if_valid,
                 bus.if_pred_taken, bus.fetch_fault);
    endtask

    initial begin
        rst = 1'b1;
        tick(0, 0, 32'h0);
        tick(0, 0, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset imem_addr", bus.imem_addr, 32'h0);
        check("reset if_inst", bus.if_inst, NOP);
        check("reset if_valid", 32'(bus.if_valid), 32'h0);
        check("reset fault", 32'(bus.fetch_fault), 32'h0);

        tick(0, 0, 32'h0);
        check("run1 if_pc", bus.if_pc, 32'h0);
        check("run1 if_inst", bus.if_inst, 32'h0010_0093);
        check("run1 if_valid", 32'(bus.if_valid), 32'h1);
        check("run1 addr", bus.imem_addr, 32'h4);
        tick(0, 0, 32'h0);
        check("run2 if_pc", bus.if_pc, 32'h4);
        check("run2 if_inst", bus.if_inst, 32'h0020_0113);
        check("run2 addr", bus.imem_addr, 32'h8);

        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 32'h0);
            check("stall addr", bus.imem_addr, 32'h8);
            check("stall if_pc", bus.if_pc, 32'h4);
            check("stall if_inst", bus.if_inst, 32'h0020_0113);
        end
        tick(0, 0, 32'h0);
        check("resume if_pc", bus.if_pc, 32'h8);
        check("resume addr", bus.imem_addr, 32'hC);

        tick(1, 1, 32'h40);
        check("redir addr", bus.imem_addr, 32'h40);
        check("redir if_valid", 32'(bus.if_valid), 32'h0);
        check("redir if_inst", bus.if_inst, NOP);
        tick(0, 0, 32'h0);
        check("redir+1 if_pc", bus.if_pc, 32'h40);
        check("redir+1 if_valid", 32'(bus.if_valid), 32'h1);

        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 32'h0);
        check("wrap if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check("wrap addr", bus.imem_addr, 32'h0);

        tick(0, 1, 32'h20);
        tick(0, 0, 32'h0);
        check("pred if_inst", bus.if_inst, 32'hFE00_0EE3);
`ifdef FETCH_STATIC_PREDICT_EN
        check("pred addr", bus.imem_addr, 32'h1C);
        check("pred taken", 32'(bus.if_pred_taken), 32'h1);
`else
        check("pred addr", bus.imem_addr, 32'h24);
        check("pred taken", 32'(bus.if_pred_taken), 32'h0);
`endif

        for (int i = 0; i < 12; i++) begin
            tick(logic'((i % 3) == 1), logic'(i == 7), 32'h100);
        end

        tick(0, 1, 32'h42);
        check("mis addr", bus.imem_addr, 32'h42);
        check("mis if_valid", 32'(bus.if_valid), 32'h0);
        check("mis fault pre", 32'(bus.fetch_fault), 32'h0);
        tick(0, 0, 32'h0);
        check("mis fault", 32'(bus.fetch_fault), 32'h1);
        check("mis hold addr", bus.imem_addr, 32'h42);
        tick(0, 1, 32'h80);
        check("halt ignores redirect", bus.imem_addr, 32'h42);
        check("halt fault sticky", 32'(bus.fetch_fault), 32'h1);
        tick(1, 0, 32'h0);

        rst = 1'b1;
        tick(0, 1, 32'h80);
        rst = 1'b0;
        check("rst clears fault", 32'(bus.fetch_fault), 32'h0);
        check("rst addr", bus.imem_addr, 32'h0);
        tick(0, 0, 32'h0);
        check("post-rst if_inst", bus.if_inst, 32'h0010_0093);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the pipelined CPU.
- Owns the PC register and drives the instruction-memory read address.
- Captures the fetched word into the IF/ID pipeline register consumed by decode.
- Handles decode stalls and execute-stage redirects (branch/jump resolution, mispredict recovery), and raises a sticky fetch fault that feeds the CPU halt.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
NOP_INST, 32'h00000013, word placed in IF/ID on a bubble (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode hazard; hold PC and IF/ID
redirect_valid  input  1  execute resolved a taken branch/jump or a mispredict
redirect_pc  input  32  target PC for the redirect
imem_addr  output  32  instruction memory address; combinational = pc
imem_data  input  32  instruction word; combinational read of imem_addr, same cycle
if_pc  output  32  IF/ID: PC of the held instruction
if_inst  output  32  IF/ID: instruction word
if_valid  output  1  IF/ID: entry holds a real instruction
if_pred_taken  output  1  IF/ID: fetch predicted taken (0 when the feature is off)
fetch_fault  output  1  sticky misaligned-fetch flag; CPU ORs it into halt

Behaviour:
- Reset (rst=1 at an edge; wins over all other inputs, including when in HALTED):
  - pc=RESET_PC
  - if_pc=0, if_inst=NOP_INST, if_valid=0, if_pred_taken=0
  - fetch_fault=0, state=RUN
- States:
  - RUN: normal fetch.
  - HALTED: entered when a misaligned PC is fetched. Left only by reset.
- Next-PC default: pc+4, 32-bit wrap (32'hFFFFFFFC -> 0). No carry out.
- Priority at each edge in RUN, highest first:
  1. redirect_valid=1:
     - pc<=redirect_pc
     - IF/ID <= bubble (if_valid=0, if_inst=NOP_INST, if_pred_taken=0, if_pc=redirect_pc)
     - Overrides stall in the same cycle.
  2. pc[1:0]!=0:
     - Go to HALTED, fetch_fault<=1, IF/ID <= bubble, pc holds.
  3. stall=1:
     - pc and all IF/ID fields hold their values.
  4. Otherwise:
     - if_pc<=pc, if_inst<=imem_data, if_valid<=1
     - pc<=next-PC
- HALTED:
  - pc and IF/ID are frozen.
  - fetch_fault stays 1.
  - A redirect is ignored.
- Latency:
  - An instruction at address A is visible on if_inst one cycle after pc==A with no stall.
  - After a redirect, the first target instruction is visible 2 cycles after redirect_valid is sampled.
- A redirect to a misaligned target is accepted. The fault fires on the next cycle's fetch, and the bubble from the redirect remains in IF/ID.
- imem_addr is always equal to pc, including during a stall. Memory reads while stalled are harmless.

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN
- Defined:
  - Combinationally predecodes imem_data in case 4 only.
  - JAL (opcode 7'b1101111): next-PC = pc + sign-extended J-immediate, if_pred_taken<=1.
  - B-type (opcode 7'b1100011) with inst[31]=1 (backward): next-PC = pc + sign-extended B-immediate, if_pred_taken<=1.
  - Everything else: pc+4, if_pred_taken<=0.
  - Execute uses if_pred_taken to decide whether a mispredict redirect is needed.
- Not defined:
  - Next-PC is always pc+4 and if_pred_taken is constant 0.
  - No predecode logic is present.

Test Plan:
- Reset then run: RESET_PC=0, imem returns 32'h00100093 at 0 and 32'h00200113 at 4, no stall. Required: cycle 1 gives if_pc=0, if_inst=32'h00100093, if_valid=1; cycle 2 gives if_pc=4; imem_addr sequence 0,4,8.
- Stall hold: assert stall for 3 cycles with pc=8. Required: imem_addr stays 8; if_pc/if_inst/if_valid unchanged for 3 cycles; the fetch at 8 resumes the cycle after stall drops.
- Redirect vs stall: stall=1 and redirect_valid=1 with redirect_pc=32'h40 in the same cycle. Required: next cycle pc=32'h40, if_valid=0, if_inst=32'h00000013; one cycle later if_pc=32'h40, if_valid=1.
- Misaligned fault: redirect_pc=32'h42. Required: 1 cycle later pc=32'h42 with a bubble; the next edge sets fetch_fault=1; pc stays 32'h42 thereafter; a further redirect to 32'h80 is ignored. Asserting rst clears fetch_fault and sets pc=RESET_PC.
- Wrap: pc=32'hFFFFFFFC, no stall. Required: next pc=0, and if_pc=32'hFFFFFFFC.
- FETCH_STATIC_PREDICT_EN: at pc=32'h20, fetch 32'hFE000EE3 (beq x0,x0,-4). Required: next pc=32'h1C, if_pred_taken=1. With the macro off: next pc=32'h24, if_pred_taken=0.
